mac4_seq: RTL and testbench
===========================

# mac4_seq

Sequential multiply-accumulate stage that consumes the 8-bit products of 4-bit operand pairs and sums a fixed-length series of them into one accumulated result. Operand pairs arrive one per cycle over a valid/ready handshake. Each pair is multiplied combinationally and added into a registered accumulator. After `N_TERMS` pairs the result is presented on a valid/ready output port and held until it is taken. It sits directly downstream of the 4x4 array multiplier datapath and turns single products into dot-product sums for the next consumer.

## Interface
- `ACC_W`, default 10: accumulator width in bits; must be ≥ 8.
- `N_TERMS`, default 8: products summed per result; range 1..255.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `clr`  in  1: synchronous abort/clear, active-high, legal in any state.
- `in_valid`  in  1: operand pair `a`/`b` is valid.
- `in_ready`  out  1: block accepts an operand pair this cycle.
- `a`  in  4: unsigned multiplicand.
- `b`  in  4: unsigned multiplier.
- `out_valid`  out  1: `acc` holds a finished result.
- `out_ready`  in  1: downstream takes the result.
- `acc`  out  `ACC_W`: accumulator value, unsigned.
- `ovf`  out  1: sticky flag; set if any addition in the current series exceeded 2^`ACC_W`−1.

## Operation
- **Transfers.**
  - Input transfer (in-fire) = `in_valid & in_ready`.
  - Output transfer (out-fire) = `out_valid & out_ready`.
- **FSM states.**
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- **ACCUM behaviour.**
  - On in-fire: `acc` ← (`acc` + `a`×`b`) mod 2^`ACC_W`, and `cnt` ← `cnt`+1.
  - If the true sum is ≥ 2^`ACC_W`, `ovf` ← 1. `ovf` is sticky.
  - On in-fire with `cnt` = `N_TERMS`−1: go to HOLD.
- **HOLD behaviour.**
  - `acc` and `ovf` are frozen; `a`, `b` and `in_valid` are ignored.
  - On out-fire: `acc`←0, `ovf`←0, `cnt`←0, go to ACCUM.
- **Product width.** The product is 8-bit unsigned (max 225) and is zero-extended to `ACC_W` before the add.
- **Internal counter.** `cnt` is an internal term counter, width ⌈log2(`N_TERMS`+1)⌉.
- **Priority (highest first).**
  1. `rst`: all state is cleared.
  2. `clr`: acc=0, ovf=0, cnt=0, state=ACCUM. Any simultaneous in-fire or out-fire is discarded; the upstream side sees the handshake complete but the data is dropped.
  3. Normal handshakes.
- **Boundary conditions.**
  - `in_valid` gaps: `acc` and `cnt` are held; there is no timeout.
  - `N_TERMS`=1: every in-fire moves directly to HOLD.
  - `out_ready` held high in ACCUM has no effect.
  - Reset asserted mid-series or in HOLD: the partial or pending result is lost.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `acc`=0, `ovf`=0; state ACCUM; `cnt`=0.
- **Accumulator latency:** `acc` reflects an in-fire on the next rising edge. There is no multiplier pipeline register; the multiply and add are one combinational path.
- **Result latency:** `out_valid` rises on the edge that captures the `N_TERMS`-th in-fire, so it is visible in the cycle after that fire.
- **Result hold:** `acc`, `ovf` and `out_valid` remain stable while `out_valid`=1 and `out_ready`=0.
- **Throughput:** after out-fire, `in_ready`=1 in the next cycle. The minimum period is `N_TERMS`+1 cycles per result with continuous valid and ready.
- **Output timing:** all outputs come straight from registers or from the FSM state. There is no combinational path from any input to `in_ready` or `out_valid`.

## Structure
- **Package `mac4_pkg`:**
  - state enum {ACCUM, HOLD};
  - default constants `ACC_W_DEF`=10 and `N_TERMS_DEF`=8;
  - product width constant `PROD_W`=8.
- **Sub-module `mul4x4_comb`:** purely combinational 4x4 unsigned multiplier, ports `a[3:0]`, `b[3:0]` → `p[7:0]`, instantiated once.
- **Top level:** FSM, counter, accumulator adder with carry-out for `ovf`, and handshake logic.

## Test plan
- **Basic sum:** after reset, present a=k, b=1 for k=1..8 back-to-back, `out_ready`=1.
  - `out_valid` rises exactly 1 cycle after the 8th fire.
  - acc=36, ovf=0.
  - `in_ready` returns to 1 the next cycle.
- **Overflow:** 8 pairs of a=15, b=15 (true sum 1800).
  - acc=1800 mod 1024 = 776, ovf=1.
  - ovf=0 again after out-fire.
- **Backpressure:** complete a series, then hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with a=3, b=3.
  - `acc` stable, `in_ready`=0, no term counted.
  - On `out_ready`=1 the next series starts from acc=0.
- **Clear mid-series:** after 3 fires (a=2, b=2, acc=12), assert `clr` together with `in_valid` (a=5, b=5).
  - Next cycle acc=0, cnt=0, ovf=0.
  - The next 8 pairs of a=1, b=1 give acc=8.
- **Reset in HOLD and input gaps:** assert `rst` while `out_valid`=1.
  - Next cycle `out_valid`=0, acc=0, `in_ready`=1.
  - Then send 8 pairs of a=2, b=3 with random 0–3-cycle `in_valid` gaps: acc=48.

Source files
------------

// File: rtl/mac4_pkg.sv
// rtl/mac4_pkg.sv - shared types and constants for the mac4 accumulate stage
package mac4_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int ACC_W_DEF   = 10;
  localparam int N_TERMS_DEF = 8;
  localparam int PROD_W      = 8;

endpackage

// File: rtl/mul4x4_comb.sv
// rtl/mul4x4_comb.sv - combinational 4x4 unsigned multiplier
module mul4x4_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  // Shift-and-add over the four partial-product rows of the array.
  always_comb begin
    p = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p + ({4'd0, a} << i);
    end
  end

endmodule

// File: rtl/mac4_seq.sv
// rtl/mac4_seq.sv - sums N_TERMS 4x4 products into one handshaked result
module mac4_seq
  import mac4_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W:0]      sum;

  mul4x4_comb u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  // Extra top bit of the adder is the carry-out that feeds the sticky ovf.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= ACCUM;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac4_seq.sv
// tb/tb_mac4_seq.sv - self-checking bench for mac4_seq
module tb_mac4_seq;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       in_valid, out_ready;
  logic [3:0] a, b;
  logic       in_ready, out_valid, ovf;
  logic [9:0] acc;

  logic       in_valid1, out_ready1;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] acc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac4_seq dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf)
  );

  mac4_seq #(.ACC_W(8), .N_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready1), .acc(acc1), .ovf(ovf1)
  );

  typedef struct {
    int a;
    int b;
    int exp_acc;
    int exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    int t = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Expected result of a series: plain arithmetic on the true running total.
  function automatic int model_acc(input int total);
    return total % 1024;
  endfunction

  function automatic int model_ovf(input int total);
    return (total >= 1024) ? 1 : 0;
  endfunction

  initial begin
    int total, held, g, x, y;

    vecs[0] = '{1, 1, 8, 0};
    vecs[1] = '{15, 15, 776, 1};
    vecs[2] = '{2, 3, 48, 0};
    vecs[3] = '{10, 12, 960, 0};
    vecs[4] = '{11, 12, 32, 1};
    vecs[5] = '{0, 15, 0, 0};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 4'd0; b = 4'd0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_acc", 32'(acc), 0);
    chk("reset_ovf", 32'(ovf), 0);

    // Basic sum 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(4'(k), 4'd1);
      if (k == 7) chk("basic_not_early", 32'(out_valid), 0);
    end
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_acc", 32'(acc), 36);
    chk("basic_ovf", 32'(ovf), 0);
    step();
    chk("basic_in_ready_back", 32'(in_ready), 1);
    chk("basic_acc_cleared", 32'(acc), 0);
    out_ready = 1'b0;

    // Table of constant-pair series
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 8; k++) send(4'(vecs[v].a), 4'(vecs[v].b));
      chk($sformatf("tbl%0d_out_valid", v), 32'(out_valid), 1);
      chk($sformatf("tbl%0d_acc", v), 32'(acc), 32'(vecs[v].exp_acc));
      chk($sformatf("tbl%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("tbl%0d_ovf_clr", v), 32'(ovf), 0);
      chk($sformatf("tbl%0d_in_ready", v), 32'(in_ready), 1);
    end

    // Backpressure: pending result ignores inputs
    for (int k = 0; k < 8; k++) send(4'd5, 4'd1);
    a = 4'd3; b = 4'd3; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_acc_stable", 32'(acc), 40);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_restart_acc", 32'(acc), 0);
    step();
    chk("bp_first_term", 32'(acc), 9);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) send(4'd3, 4'd3);
    chk("bp_series_acc", 32'(acc), 72);
    chk("bp_series_valid", 32'(out_valid), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Clear mid-series with a simultaneous in-fire
    for (int k = 0; k < 3; k++) send(4'd2, 4'd2);
    chk("clr_pre_acc", 32'(acc), 12);
    clr = 1'b1; a = 4'd5; b = 4'd5; in_valid = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc", 32'(acc), 0);
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    for (int k = 1; k <= 8; k++) begin
      send(4'd1, 4'd1);
      if (k == 7) chk("clr_cnt_restart", 32'(out_valid), 0);
    end
    chk("clr_series_acc", 32'(acc), 8);
    chk("clr_series_valid", 32'(out_valid), 1);

    // Clear while holding an overflowed result
    out_ready = 1'b1; step(); out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(4'd15, 4'd15);
    chk("clr_hold_ovf_pre", 32'(ovf), 1);
    clr = 1'b1; out_ready = 1'b1;
    step();
    clr = 1'b0; out_ready = 1'b0;
    chk("clr_hold_valid", 32'(out_valid), 0);
    chk("clr_hold_ovf", 32'(ovf), 0);

    // Reset in HOLD, then gapped input
    for (int k = 0; k < 8; k++) send(4'd4, 4'd4);
    chk("rst_hold_pre", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hold_valid", 32'(out_valid), 0);
    chk("rst_hold_acc", 32'(acc), 0);
    chk("rst_hold_in_ready", 32'(in_ready), 1);
    for (int k = 0; k < 8; k++) begin
      g = $urandom_range(0, 3);
      held = acc;
      for (int c = 0; c < g; c++) begin
        step();
        chk("gap_acc_held", 32'(acc), 32'(held));
      end
      send(4'd2, 4'd3);
    end
    chk("gap_acc", 32'(acc), 48);
    chk("gap_valid", 32'(out_valid), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Randomized series against the arithmetic model
    for (int s = 0; s < 20; s++) begin
      total = 0;
      for (int k = 0; k < 8; k++) begin
        x = $urandom_range(0, 15);
        y = $urandom_range(0, 15);
        g = $urandom_range(0, 2);
        for (int c = 0; c < g; c++) step();
        send(4'(x), 4'(y));
        total += x * y;
        chk("rnd_running_acc", 32'(acc), 32'(model_acc(total)));
      end
      chk("rnd_ovf", 32'(ovf), 32'(model_ovf(total)));
      chk("rnd_valid", 32'(out_valid), 1);
      g = $urandom_range(0, 3);
      for (int c = 0; c < g; c++) begin
        step();
        chk("rnd_hold_acc", 32'(acc), 32'(model_acc(total)));
      end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("rnd_release", 32'(in_ready), 1);
    end

    // Single-term configuration: every fire completes a result
    a = 4'd15; b = 4'd15; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("n1_valid", 32'(out_valid1), 1);
    chk("n1_acc", 32'(acc1), 225);
    chk("n1_ovf", 32'(ovf1), 0);
    chk("n1_in_ready", 32'(in_ready1), 0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("n1_release", 32'(in_ready1), 1);
    chk("n1_acc_clr", 32'(acc1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
